// File: rtl/aes_pipe_scheduler.sv
// Two-requester round-robin front end for a shared, fixed-latency pipelined AES core.
// Results are steered back to their owner by a tag pipe that runs in lockstep with the core.
module aes_pipe_scheduler #(
    parameter int KEY_SIZE        = 128,
    parameter int LATENCY         = 10,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [127:0]        req0_data,
    input  logic [KEY_SIZE-1:0] req0_key,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [127:0]        req1_data,
    input  logic [KEY_SIZE-1:0] req1_key,
    output logic                core_valid,
    output logic [127:0]        core_data,
    output logic [KEY_SIZE-1:0] core_key,
    input  logic                core_result_valid,
    input  logic [127:0]        core_result,
    output logic                rsp0_valid,
    output logic [127:0]        rsp0_data,
    output logic                rsp1_valid,
    output logic [127:0]        rsp1_data,
    input  logic                drain,
    output logic                idle,
    output logic                error,
    output logic [3:0]          out0_count,
    output logic [3:0]          out1_count
);

    localparam logic [3:0] LP_MAX = 4'(MAX_OUTSTANDING);

    logic                r_last_grant;
    logic                r_core_valid;
    logic                r_core_owner;
    logic [127:0]        r_core_data;
    logic [KEY_SIZE-1:0] r_core_key;
    logic [LATENCY-1:0]  r_tag_v;
    logic [LATENCY-1:0]  r_tag_o;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic [127:0]        r_rsp0_data;
    logic [127:0]        r_rsp1_data;
    logic                r_error;
    logic [3:0]          r_out0;
    logic [3:0]          r_out1;

    logic w_under0, w_under1;
    logic w_elig0, w_elig1;
    logic w_grant0, w_grant1;
    logic w_acc0, w_acc1;
    logic w_exp_v, w_exp_o;
    logic w_hit;

    assign w_under0 = (r_out0 < LP_MAX);
    assign w_under1 = (r_out1 < LP_MAX);
    assign w_elig0  = req0_valid & w_under0;
    assign w_elig1  = req1_valid & w_under1;

    // r_last_grant==1 means req1 won most recently, so req0 takes the next tie.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_grant0 = r_last_grant;
            w_grant1 = ~r_last_grant;
        end else begin
            w_grant0 = w_elig0;
            w_grant1 = w_elig1;
        end
    end

    assign req0_ready = w_grant0 & ~drain & w_under0;
    assign req1_ready = w_grant1 & ~drain & w_under1;
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_core_valid <= 1'b0;
            r_core_owner <= 1'b0;
            r_core_data  <= '0;
            r_core_key   <= '0;
        end else begin
            r_core_valid <= w_acc0 | w_acc1;
            if (w_acc0) begin
                r_last_grant <= 1'b0;
                r_core_owner <= 1'b0;
                r_core_data  <= req0_data;
                r_core_key   <= req0_key;
            end else if (w_acc1) begin
                r_last_grant <= 1'b1;
                r_core_owner <= 1'b1;
                r_core_data  <= req1_data;
                r_core_key   <= req1_key;
            end
        end
    end

    // Tag enters from the registered issue, so its last stage lines up with the core output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_v <= '0;
            r_tag_o <= '0;
        end else begin
            r_tag_v[0] <= r_core_valid;
            r_tag_o[0] <= r_core_owner;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                r_tag_v[k] <= r_tag_v[k-1];
                r_tag_o[k] <= r_tag_o[k-1];
            end
        end
    end

    assign w_exp_v = r_tag_v[LATENCY-1];
    assign w_exp_o = r_tag_o[LATENCY-1];
    assign w_hit   = core_result_valid & w_exp_v;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
            r_error      <= 1'b0;
        end else begin
            r_rsp0_valid <= w_hit & ~w_exp_o;
            r_rsp1_valid <= w_hit & w_exp_o;
            if (w_hit && !w_exp_o) r_rsp0_data <= core_result;
            if (w_hit && w_exp_o)  r_rsp1_data <= core_result;
            if (core_result_valid != w_exp_v) r_error <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out0 <= '0;
            r_out1 <= '0;
        end else begin
            if (w_acc0 && !r_rsp0_valid && (r_out0 < LP_MAX)) r_out0 <= r_out0 + 4'd1;
            else if (!w_acc0 && r_rsp0_valid && (r_out0 != 4'd0)) r_out0 <= r_out0 - 4'd1;
            if (w_acc1 && !r_rsp1_valid && (r_out1 < LP_MAX)) r_out1 <= r_out1 + 4'd1;
            else if (!w_acc1 && r_rsp1_valid && (r_out1 != 4'd0)) r_out1 <= r_out1 - 4'd1;
        end
    end

    assign core_valid = r_core_valid;
    assign core_data  = r_core_data;
    assign core_key   = r_core_key;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign error      = r_error;
    assign out0_count = r_out0;
    assign out1_count = r_out1;
    assign idle       = (r_out0 == 4'd0) && (r_out1 == 4'd0) && (r_tag_v == '0) &&
                        !r_core_valid && !r_rsp0_valid && !r_rsp1_valid;

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Directed bench for aes_pipe_scheduler with a fixed-latency behavioural AES core model.
module tb_aes_pipe_scheduler;

    localparam int LAT  = 10;
    localparam int MAXO = 4;
    localparam int KS   = 128;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K31  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'hdeadbeef_00000000_cafef00d_00000000;
    localparam logic [127:0] D0   = 128'h0a0a0000_00000000_00000000_00000000;
    localparam logic [127:0] D1   = 128'h0b0b0000_00000000_00000000_00010000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [127:0]  req0_data = '0, req1_data = '0;
    logic [KS-1:0] req0_key = '0, req1_key = '0;
    logic          core_valid;
    logic [127:0]  core_data;
    logic [KS-1:0] core_key;
    logic          core_result_valid;
    logic [127:0]  core_result;
    logic          rsp0_valid, rsp1_valid;
    logic [127:0]  rsp0_data, rsp1_data;
    logic          drain = 1'b0;
    logic          idle, error;
    logic [3:0]    out0_count, out1_count;
    logic          inj = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    aes_pipe_scheduler #(
        .KEY_SIZE(KS),
        .LATENCY(LAT),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
        .core_valid(core_valid), .core_data(core_data), .core_key(core_key),
        .core_result_valid(core_result_valid), .core_result(core_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .drain(drain), .idle(idle), .error(error),
        .out0_count(out0_count), .out1_count(out1_count)
    );

    // Core model: known vector returns the FIPS-197 ciphertext, anything else data^key.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == PT && k == K31) return CT;
        return d ^ k;
    endfunction

    logic         m_v [LAT];
    logic [127:0] m_d [LAT];

    always @(posedge clock) begin
        m_v[0] <= core_valid;
        m_d[0] <= core_fn(core_data, core_key);
        for (int k = 1; k < LAT; k++) begin
            m_v[k] <= m_v[k-1];
            m_d[k] <= m_d[k-1];
        end
    end

    assign core_result_valid = m_v[LAT-1] | inj;
    assign core_result       = m_d[LAT-1];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain      = 1'b0;
        inj        = 1'b0;
        reset      = 1'b0;
        repeat (LAT + 3) tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic logic [127:0] alt_data(input int k);
        return (k % 2 == 0) ? D0 + 128'(k) : D1 + 128'(k);
    endfunction

    initial begin
        do_reset();

        // Single request with the FIPS-197 vector
        req0_valid = 1'b1; req0_data = PT; req0_key = K31;
        #1;
        check("rst_error", error, 1'b0);
        check("rst_core_valid", core_valid, 1'b0);
        check("rst_core_data", core_data, '0);
        check("rst_idle", idle, 1'b1);
        check("t1_ready0", req0_ready, 1'b1);
        check("t1_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_core_valid", core_valid, 1'b1);
        check("t1_core_data", core_data, PT);
        check("t1_core_key", core_key, K31);
        check("t1_out0_one", out0_count, 4'd1);
        for (int t = 2; t <= LAT + 3; t++) begin
            tick();
            if (t == 2) check("t1_core_valid_drop", core_valid, 1'b0);
            check("t1_rsp0_valid", rsp0_valid, (t == LAT + 2));
            check("t1_rsp1_valid", rsp1_valid, 1'b0);
            if (t == LAT + 2) begin
                check("t1_rsp0_data", rsp0_data, CT);
                check("t1_out0_still", out0_count, 4'd1);
            end
            if (t == LAT + 3) begin
                check("t1_out0_zero", out0_count, 4'd0);
                check("t1_idle", idle, 1'b1);
            end
        end

        // Both requesters valid for 8 cycles: alternating grants, req0 first
        do_reset();
        req0_key = KEY2; req1_key = KEY2;
        for (int t = 0; t <= LAT + 11; t++) begin
            req0_valid = (t < 8);
            req1_valid = (t < 8);
            req0_data  = D0 + 128'(t);
            req1_data  = D1 + 128'(t);
            #1;
            if (t < 8) begin
                check("t2_ready0", req0_ready, (t % 2 == 0));
                check("t2_ready1", req1_ready, (t % 2 == 1));
            end
            if (t >= 1 && t <= 8) begin
                check("t2_core_valid", core_valid, 1'b1);
                check("t2_core_data", core_data, alt_data(t - 1));
            end
            if (t >= LAT + 2 && t < LAT + 10) begin
                if ((t - LAT - 2) % 2 == 0) begin
                    check("t2_rsp0_valid", rsp0_valid, 1'b1);
                    check("t2_rsp1_quiet", rsp1_valid, 1'b0);
                    check("t2_rsp0_data", rsp0_data, alt_data(t - LAT - 2) ^ KEY2);
                end else begin
                    check("t2_rsp1_valid", rsp1_valid, 1'b1);
                    check("t2_rsp0_quiet", rsp0_valid, 1'b0);
                    check("t2_rsp1_data", rsp1_data, alt_data(t - LAT - 2) ^ KEY2);
                end
            end else begin
                check("t2_rsp0_none", rsp0_valid, 1'b0);
                check("t2_rsp1_none", rsp1_valid, 1'b0);
            end
            tick();
        end
        check("t2_idle", idle, 1'b1);

        // req0 alone against the outstanding limit
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            logic [3:0] exp_cnt;
            req0_valid = 1'b1;
            req0_data  = D0 + 128'(t);
            #1;
            exp_cnt = (t < 4) ? 4'(t) : (t <= 12) ? 4'd4 : (t <= 16) ? 4'd3 : 4'd4;
            check("t3_ready0", req0_ready, (t < 4) || (t >= 13 && t <= 16));
            check("t3_out0", out0_count, exp_cnt);
            check("t3_rsp0_valid", rsp0_valid, (t >= 12 && t <= 15));
            if (t >= 12 && t <= 15) check("t3_rsp0_data", rsp0_data, (D0 + 128'(t - 12)) ^ KEY2);
            tick();
        end

        // Drain with 3 in flight
        do_reset();
        for (int t = 0; t <= LAT + 6; t++) begin
            req0_valid = 1'b1;
            req1_valid = (t >= 3);
            req0_data  = D0 + 128'(t);
            drain      = (t >= 3);
            #1;
            check("t4_ready0", req0_ready, (t < 3));
            if (t >= 3) check("t4_ready1", req1_ready, 1'b0);
            check("t4_rsp0_valid", rsp0_valid, (t >= LAT + 2 && t <= LAT + 4));
            check("t4_rsp1_valid", rsp1_valid, 1'b0);
            if (t >= LAT + 2 && t <= LAT + 4) check("t4_rsp0_data", rsp0_data, (D0 + 128'(t - LAT - 2)) ^ KEY2);
            if (t >= 3) check("t4_idle", idle, (t >= LAT + 5));
            tick();
        end

        // Spurious core result with nothing expected
        do_reset();
        inj = 1'b1;
        #1;
        check("t5_error_before", error, 1'b0);
        tick();
        inj = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #1;
            check("t5_error_sticky", error, 1'b1);
            check("t5_rsp0_none", rsp0_valid, 1'b0);
            check("t5_rsp1_none", rsp1_valid, 1'b0);
            check("t5_out0", out0_count, 4'd0);
            tick();
        end

        // Reset mid-operation with 5 in flight
        do_reset();
        for (int t = 0; t < 5; t++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data = D0 + 128'(t); req1_data = D1 + 128'(t);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("t6_out0_pre", out0_count, 4'd3);
        check("t6_out1_pre", out1_count, 4'd2);
        check("t6_idle_pre", idle, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_core_valid", core_valid, 1'b0);
        check("t6_out0", out0_count, 4'd0);
        check("t6_out1", out1_count, 4'd0);
        check("t6_idle", idle, 1'b1);
        check("t6_error", error, 1'b0);
        check("t6_core_data", core_data, '0);
        repeat (2) tick();
        reset = 1'b1;
        for (int t = 0; t < LAT + 4; t++) begin
            tick();
            check("t6_rsp0_none", rsp0_valid, 1'b0);
            check("t6_rsp1_none", rsp1_valid, 1'b0);
        end
        check("t6_error_late", error, 1'b1);
        req0_valid = 1'b1;
        #1;
        check("t6_ready_resume", req0_ready, 1'b1);
        req0_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
